// File: rtl/ipsmacge_pulse_stretch.sv
// Edge-triggered pulse stretcher: rise on idat starts an opulse of max(cfg_len,1) cycles,
// optionally followed by a hold-off dead time; accepted/dropped triggers are counted.
module ipsmacge_pulse_stretch #(
  parameter int CW     = 8,
  parameter bit RETRIG = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          idat,
  input  logic          en,
  input  logic          clr,
  input  logic [CW-1:0] cfg_len,
  input  logic [CW-1:0] cfg_holdoff,
  output logic          opulse,
  output logic          obusy,
  output logic          oovr,
  output logic [15:0]   oevt_cnt,
  output logic [15:0]   odrop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_STRETCH = 2'b01,
    S_HOLD    = 2'b10
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_idat_d;
  logic          r_arm;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] r_shadow;
  logic [CW-1:0] w_shadow_nxt;
  logic          r_pulse;
  logic          r_busy;
  logic          r_ovr;
  logic [15:0]   r_evt_cnt;
  logic [15:0]   r_drop_cnt;
  logic          w_trig;
  logic          w_accept;
  logic          w_drop;
  logic          w_pulse_nxt;
  logic          w_busy_nxt;
  logic [CW-1:0] w_len_m1;

  // r_arm masks the first cycle after reset so a high idat is seen as a level, not a rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idat_d <= 1'b0;
      r_arm    <= 1'b0;
    end else begin
      r_idat_d <= idat;
      r_arm    <= 1'b1;
    end
  end

  assign w_trig   = en & r_arm & idat & ~r_idat_d;
  assign w_len_m1 = (cfg_len == '0) ? '0 : cfg_len - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shadow <= w_shadow_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    w_accept     = 1'b0;
    w_drop       = 1'b0;
    if (!en) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            w_accept     = 1'b1;
            w_state_nxt  = S_STRETCH;
            w_cnt_nxt    = w_len_m1;
            w_shadow_nxt = cfg_holdoff;
          end
        end
        S_STRETCH: begin
          if (w_trig && (RETRIG != 1'b0)) begin
            w_accept     = 1'b1;
            w_cnt_nxt    = w_len_m1;
            w_shadow_nxt = cfg_holdoff;
          end else begin
            w_drop = w_trig;
            if (r_cnt == '0) begin
              if (r_shadow != '0) begin
                w_state_nxt = S_HOLD;
                w_cnt_nxt   = r_shadow - 1'b1;
              end else begin
                w_state_nxt = S_IDLE;
              end
            end else begin
              w_cnt_nxt = r_cnt - 1'b1;
            end
          end
        end
        S_HOLD: begin
          w_drop = w_trig;
          if (r_cnt == '0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_pulse_nxt = (w_state_nxt == S_STRETCH);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_pulse <= w_pulse_nxt;
      r_busy  <= w_busy_nxt;
      r_ovr   <= w_drop;
    end
  end

  // clr wins over the old value but still counts an event in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evt_cnt <= '0;
    end else if (clr) begin
      r_evt_cnt <= {15'd0, w_accept};
    end else if (w_accept && (r_evt_cnt != 16'hFFFF)) begin
      r_evt_cnt <= r_evt_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (clr) begin
      r_drop_cnt <= {15'd0, w_drop};
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign opulse    = r_pulse;
  assign obusy     = r_busy;
  assign oovr      = r_ovr;
  assign oevt_cnt  = r_evt_cnt;
  assign odrop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_ipsmacge_pulse_stretch.sv
// Bench for ipsmacge_pulse_stretch: per-cycle vector table on a RETRIG=0 instance,
// then directed sequences for retrigger, reset abort, clear and saturation.
module tb_ipsmacge_pulse_stretch;

  logic        clk;
  logic        rst;
  logic        idat;
  logic        en;
  logic        clr;
  logic [7:0]  cfg_len;
  logic [7:0]  cfg_holdoff;
  logic        p0, b0, o0, p1, b1, o1;
  logic [15:0] evt0, drop0, evt1, drop1;

  int total;
  int bad;

  typedef struct {
    logic       i;
    logic       e;
    logic       c;
    logic [7:0] len;
    logic [7:0] hold;
    logic       ep;
    logic       eb;
    logic       eo;
  } vec_t;

  vec_t tv[$];

  ipsmacge_pulse_stretch #(.CW(8), .RETRIG(1'b0)) u0 (
    .clk(clk), .rst(rst), .idat(idat), .en(en), .clr(clr),
    .cfg_len(cfg_len), .cfg_holdoff(cfg_holdoff),
    .opulse(p0), .obusy(b0), .oovr(o0), .oevt_cnt(evt0), .odrop_cnt(drop0)
  );

  ipsmacge_pulse_stretch #(.CW(8), .RETRIG(1'b1)) u1 (
    .clk(clk), .rst(rst), .idat(idat), .en(en), .clr(clr),
    .cfg_len(cfg_len), .cfg_holdoff(cfg_holdoff),
    .opulse(p1), .obusy(b1), .oovr(o1), .oevt_cnt(evt1), .odrop_cnt(drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic i, input logic e, input logic c, input logic [7:0] l,
                     input logic [7:0] h, input logic ep, input logic eb, input logic eo);
    vec_t v;
    v.i = i; v.e = e; v.c = c; v.len = l; v.hold = h; v.ep = ep; v.eb = eb; v.eo = eo;
    tv.push_back(v);
  endtask

  // single accepted rise with len=1, hold=0: back in IDLE two cycles later
  task automatic accept_one();
    idat = 1'b1; tick();
    idat = 1'b0; tick(); tick(); tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0; idat = 1'b0; en = 1'b1; clr = 1'b0;
    cfg_len = 8'd4; cfg_holdoff = 8'd0;
    #2 rst = 1'b1;
    #1;
    chk("reset_outputs", {p0, b0, o0, evt0, drop0}, 35'd0);
    tick();
    rst = 1'b0;
    tick(); tick();

    // idat, en, clr, len, hold | opulse, obusy, oovr
    add(0,1,0,4,0, 0,0,0);
    add(1,1,0,4,0, 0,0,0);
    add(1,1,0,4,0, 1,1,0);
    add(0,1,0,7,0, 1,1,0);
    add(0,1,0,7,0, 1,1,0);
    add(0,1,0,7,0, 1,1,0);
    add(0,1,0,7,0, 0,0,0);
    add(0,1,0,5,3, 0,0,0);
    add(1,1,0,5,3, 0,0,0);
    add(0,1,0,5,3, 1,1,0);
    add(1,1,0,1,0, 1,1,0);
    add(0,1,0,1,0, 1,1,1);
    add(0,1,0,1,0, 1,1,0);
    add(0,1,0,1,0, 1,1,0);
    add(0,1,0,1,0, 0,1,0);
    add(0,1,0,1,0, 0,1,0);
    add(1,1,0,1,0, 0,1,0);
    add(0,1,0,1,0, 0,0,1);
    add(0,1,0,1,0, 0,0,0);
    add(1,1,0,2,1, 0,0,0);
    add(0,1,0,2,1, 1,1,0);
    add(0,1,0,2,1, 1,1,0);
    add(0,1,0,2,1, 0,1,0);
    add(1,1,0,0,0, 0,0,0);
    add(0,1,0,0,0, 1,1,0);
    add(0,1,0,0,0, 0,0,0);
    add(1,1,0,4,0, 0,0,0);
    add(0,1,0,4,0, 1,1,0);
    add(0,0,0,4,0, 1,1,0);
    add(1,0,0,4,0, 0,0,0);
    add(1,1,0,4,0, 0,0,0);
    add(0,1,0,4,0, 0,0,0);
    add(0,1,0,4,0, 0,0,0);

    for (int k = 0; k < tv.size(); k++) begin
      idat = tv[k].i; en = tv[k].e; clr = tv[k].c;
      cfg_len = tv[k].len; cfg_holdoff = tv[k].hold;
      chk($sformatf("vec%0d_pulse_busy_ovr", k), {p0, b0, o0}, {tv[k].ep, tv[k].eb, tv[k].eo});
      tick();
    end
    chk("table_evt_cnt", evt0, 16'd5);
    chk("table_drop_cnt", drop0, 16'd2);

    // retrigger: rises at n and n+3, len=5
    rst = 1'b1; tick(); rst = 1'b0;
    idat = 1'b0; en = 1'b1; cfg_len = 8'd5; cfg_holdoff = 8'd0;
    tick(); tick();
    idat = 1'b1; tick();
    for (int k = 1; k <= 9; k++) begin
      idat = (k == 3);
      chk($sformatf("retrig_c%0d_u1", k), {p1, o1}, {(k <= 8) ? 1'b1 : 1'b0, 1'b0});
      chk($sformatf("noretrig_c%0d_u0", k), {p0, o0}, {(k <= 5) ? 1'b1 : 1'b0, (k == 4) ? 1'b1 : 1'b0});
      tick();
    end
    chk("retrig_counts_u1", {evt1, drop1}, {16'd2, 16'd0});
    chk("noretrig_counts_u0", {evt0, drop0}, {16'd1, 16'd1});

    // reset mid-pulse, idat held high through release
    idat = 1'b1; tick(); tick();
    chk("pulse_before_rst", {p0, p1}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_clear", {p0, b0, o0, p1, b1, o1, evt0, drop0, evt1}, 54'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("no_pulse_after_rst_c%0d", k), {p0, p1, b0, b1, evt0, evt1}, 36'd0);
      tick();
    end

    // clear interaction
    idat = 1'b0; cfg_len = 8'd1; cfg_holdoff = 8'd0; tick();
    accept_one(); accept_one();
    chk("two_accepts", evt0, 16'd2);
    idat = 1'b1; clr = 1'b1; tick();
    clr = 1'b0; idat = 1'b0; tick(); tick(); tick();
    chk("clr_with_accept", evt0, 16'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_alone", {evt0, drop0, evt1}, 48'd0);

    // saturation from a preloaded count
    force u0.r_evt_cnt = 16'hFFFD;
    #1;
    release u0.r_evt_cnt;
    accept_one();
    chk("evt_sat_fffe", evt0, 16'hFFFE);
    accept_one();
    chk("evt_sat_ffff", evt0, 16'hFFFF);
    accept_one();
    chk("evt_sat_stick", evt0, 16'hFFFF);

    force u0.r_drop_cnt = 16'hFFFF;
    #1;
    release u0.r_drop_cnt;
    cfg_len = 8'd3;
    idat = 1'b1; tick();
    idat = 1'b0; tick();
    idat = 1'b1; tick();
    idat = 1'b0;
    chk("drop_ovr_at_sat", o0, 1'b1);
    tick(); tick(); tick();
    chk("drop_sat_stick", drop0, 16'hFFFF);
    chk("evt_still_sat", evt0, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ipsmacge_pulse_stretch.md
IPSMACGE_PULSE_STRETCH -- requirements
Module: ipsmacge_pulse_stretch

Interface
REQ-001 Parameter: CW, default 8, width of the length and hold-off configuration fields.
REQ-002 Parameter: RETRIG, default 0. 1 = a trigger during STRETCH extends the pulse; 0 = the trigger is dropped.
REQ-003 Port: clk  input  1  single clock, all logic on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: idat  input  1  level input, driven by the upstream delay_k_clk stage output.
REQ-006 Port: en  input  1  block enable.
REQ-007 Port: clr  input  1  synchronous clear pulse for both counters.
REQ-008 Port: cfg_len  input  CW  stretched pulse length in cycles; value 0 is treated as 1.
REQ-009 Port: cfg_holdoff  input  CW  dead time in cycles after a pulse; value 0 means no dead time.
REQ-010 Port: opulse  output  1  stretched pulse, registered.
REQ-011 Port: obusy  output  1  high while the FSM is not in IDLE.
REQ-012 Port: oovr  output  1  one-cycle flag for a dropped trigger.
REQ-013 Port: oevt_cnt  output  16  count of accepted triggers, saturating.
REQ-014 Port: odrop_cnt  output  16  count of dropped triggers, saturating.

Function
REQ-015 The block SHALL register idat into idat_d every cycle regardless of en. A trigger is idat=1 while idat_d=0.
REQ-016 The FSM SHALL have three states: IDLE, STRETCH, HOLD (encoded 2'b00, 2'b01, 2'b10). Encoding 2'b11 SHALL recover to IDLE on the next cycle.
REQ-017 In IDLE, a trigger with en=1 SHALL be accepted:
- next state STRETCH;
- down-counter loaded with max(cfg_len,1)-1;
- cfg_holdoff captured into a shadow register.
REQ-018 For a trigger sampled in cycle n, opulse SHALL be high in cycles n+1 through n+max(cfg_len,1) inclusive, and low otherwise.
REQ-019 In STRETCH, the counter SHALL decrement each cycle. When it reads 0:
- go to HOLD if the shadow hold-off is nonzero, with the counter loaded to shadow-1;
- otherwise go to IDLE.
REQ-020 A trigger in STRETCH with RETRIG=1 SHALL reload the counter to max(cfg_len,1)-1, increment oevt_cnt, and not assert oovr.
REQ-021 A trigger in STRETCH with RETRIG=0 SHALL be dropped: oovr=1 for the next cycle only, odrop_cnt increments.
REQ-022 HOLD SHALL last exactly shadow-hold-off cycles with opulse=0, then return to IDLE.
- Any trigger during HOLD, including its final cycle, SHALL be dropped per REQ-021.
- A trigger in the first IDLE cycle after HOLD SHALL be accepted.
REQ-023 en=0 SHALL force the FSM to IDLE on the next edge, with opulse=0 and the counter cleared.
- Triggers while en=0 SHALL be ignored: not counted, no oovr.
REQ-024 oevt_cnt SHALL increment on each accepted trigger and saturate at 16'hFFFF. odrop_cnt SHALL behave the same for dropped triggers.
REQ-025 clr=1 SHALL zero both counters on the next edge. If clr and an accept/drop occur in the same cycle, the affected counter SHALL read 1.
REQ-026 cfg_len and cfg_holdoff changes SHALL take effect only at the next accept or reload, never mid-count.
REQ-027 obusy SHALL be registered and equal (state != IDLE).

Reset
REQ-028 While rst=1, the following SHALL be 0 asynchronously: state=IDLE, idat_d, counter, shadow, opulse, obusy, oovr, oevt_cnt, odrop_cnt.
REQ-029 Release of rst SHALL be synchronous to clk. A pulse in progress when rst asserts SHALL be aborted with no resume.
REQ-030 If idat=1 at reset release, no trigger SHALL occur until idat falls and rises again. (At release idat_d=0, so idat=1 in the first cycle produces a rise unless idat_d is captured first; the implementation SHALL hold a one-cycle post-reset arm delay to meet this.)

Verification
REQ-031 cfg_len=4, cfg_holdoff=0, single idat rise at cycle 10 -> opulse high in cycles 11-14, oevt_cnt=1, obusy high in cycles 11-14.
REQ-032 RETRIG=0, cfg_len=5, cfg_holdoff=3, rises at cycles 10 and 12 -> opulse high in 11-15, HOLD in 16-18, oovr high at 13, odrop_cnt=1, oevt_cnt=1.
REQ-033 RETRIG=1, cfg_len=5, rises at cycles 10 and 13 -> opulse high continuously in 11-18, oevt_cnt=2, oovr never asserted.
REQ-034 cfg_len=0 -> one-cycle pulse. A rise in the first IDLE cycle after HOLD -> accepted.
REQ-035 en dropped mid-STRETCH -> opulse=0 on the next cycle. rst asserted mid-pulse -> all outputs 0 immediately. idat held at 1 through reset release -> no pulse.
REQ-036 Preload oevt_cnt to 16'hFFFE via 3 accepts after a forced value, or run 65537 accepts -> count sticks at 16'hFFFF. clr together with an accept -> count reads 1.
